// File: rtl/usb_reg_master_pkg.sv
// usb_reg_master_pkg: packet layout constants and helpers shared by the USB
// register-bus initiator and its read-return FIFO.
package usb_reg_master_pkg;

    // Command byte: bit position of the read flag (1 = read, 0 = write)
    localparam int unsigned CMD_READ_BIT = 0;

    // Byte offsets within a command packet
    localparam int unsigned PKT_OFS_CMD  = 0;
    localparam int unsigned PKT_OFS_ADDR = 1;
    localparam int unsigned PKT_OFS_LEN  = 2;
    localparam int unsigned PKT_OFS_DATA = 3;

    // A LEN byte of zero encodes a 256-byte transfer
    localparam bit LEN_ZERO_MEANS_256 = 1'b1;

    // Width of the remaining-bytes counter (holds 1..256)
    localparam int unsigned REM_W = 9;

    // Convert the LEN byte into a transfer length
    function automatic logic [REM_W-1:0] decode_len(input logic [7:0] len);
        if (LEN_ZERO_MEANS_256 && (len == 8'd0))
            return REM_W'(256);
        return REM_W'(len);
    endfunction

endpackage

// File: rtl/usb_rd_fifo.sv
// usb_rd_fifo: synchronous first-word-fall-through FIFO for read-return bytes.
// Ports: clk_usb/reset_n clock and async active-low reset; wr_en/wr_data push;
// rd_en pop; rd_data head of FIFO (valid when !empty); count/full/empty status.
module usb_rd_fifo
    import usb_reg_master_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_usb,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed: entries are only read once written
    always_ff @(posedge clk_usb) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/usb_reg_master.sv
// usb_reg_master: parses CMD/ADDR/LEN[/DATA] packets from an inbound byte
// stream and drives the shared register bus one byte per strobe; read data is
// returned on an outbound byte stream with backpressure.
// Ports: clk_usb/reset_n clock and async active-low reset; s_* inbound bytes;
// m_* read-return bytes; reg_* register bus; busy = work outstanding.
module usb_reg_master
    import usb_reg_master_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pRDFIFO_DEPTH = 4
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     busy
);

    localparam int unsigned CW = $clog2(pRDFIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    state_t                   state;
    logic                     is_read;
    logic [REM_W-1:0]         remaining;
    logic [pBYTECNT_SIZE-1:0] index;
    logic                     rd_pend;   // responder data valid this cycle
    logic [7:0]               rd_data;
    logic [CW-1:0]            rd_count;
    logic                     rd_full;
    logic                     rd_empty;
    logic                     credit_ok;

    usb_rd_fifo #(
        .DEPTH (pRDFIFO_DEPTH)
    ) u_rd_fifo (
        .clk_usb (clk_usb),
        .reset_n (reset_n),
        .wr_en   (rd_pend),
        .wr_data (reg_datai),
        .rd_en   (m_ready),
        .rd_data (rd_data),
        .count   (rd_count),
        .full    (rd_full),
        .empty   (rd_empty)
    );

    // Decode of registered state only; no input-to-output path
    assign s_ready = (state == ST_IDLE) || (state == ST_ADDR) ||
                     (state == ST_LEN)  || (state == ST_WRITE);
    assign m_valid = ~rd_empty;
    assign m_data  = rd_empty ? 8'h00 : rd_data;
    assign busy    = (state != ST_IDLE) || ~rd_empty || reg_write || reg_read || rd_pend;

    // Conservative credit: both outstanding reads are counted and pops ignored,
    // so the FIFO cannot overflow even if m_ready stays low
    assign credit_ok = ((32'(rd_count) + 32'(rd_pend) + 32'(reg_read)) < pRDFIFO_DEPTH) && !rd_full;

    // Packet parser and bus driver
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            is_read     <= 1'b0;
            remaining   <= '0;
            index       <= '0;
            rd_pend     <= 1'b0;
            reg_address <= '0;
            reg_bytecnt <= '0;
            reg_datao   <= '0;
            reg_read    <= 1'b0;
            reg_write   <= 1'b0;
        end else begin
            reg_read  <= 1'b0;
            reg_write <= 1'b0;
            rd_pend   <= reg_read;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        is_read <= s_data[CMD_READ_BIT];
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_valid) begin
                        reg_address <= s_data;
                        state       <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (s_valid) begin
                        remaining <= decode_len(s_data);
                        index     <= '0;
                        state     <= is_read ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (s_valid) begin
                        reg_write   <= 1'b1;
                        reg_datao   <= s_data;
                        reg_bytecnt <= index;
                        index       <= index + pBYTECNT_SIZE'(1);
                        remaining   <= remaining - REM_W'(1);
                        if (remaining == REM_W'(1))
                            state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Leave once the final strobe has been driven
                    if (remaining == '0) begin
                        state <= ST_DRAIN;
                    end else if (credit_ok) begin
                        reg_read    <= 1'b1;
                        reg_bytecnt <= index;
                        index       <= index + pBYTECNT_SIZE'(1);
                        remaining   <= remaining - REM_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_reg_master.sv
// tb_usb_reg_master: directed bench for usb_reg_master with a responder model.
module tb_usb_reg_master;

    logic       clk_usb;
    logic       reset_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] reg_address;
    logic [6:0] reg_bytecnt;
    logic [7:0] reg_datao;
    logic [7:0] reg_datai;
    logic       reg_read;
    logic       reg_write;
    logic       busy;

    int n_tests;
    int n_fail;
    int cyc;
    int both_cnt;

    typedef struct {
        logic [7:0] addr;
        logic [6:0] cnt;
        logic [7:0] data;
        int         c;
    } wr_t;

    wr_t        wr_q[$];
    int         rd_cyc_q[$];
    logic [7:0] m_q[$];
    int         m_cyc_q[$];

    usb_reg_master #(
        .pBYTECNT_SIZE (7),
        .pRDFIFO_DEPTH (4)
    ) dut (
        .clk_usb     (clk_usb),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .reg_address (reg_address),
        .reg_bytecnt (reg_bytecnt),
        .reg_datao   (reg_datao),
        .reg_datai   (reg_datai),
        .reg_read    (reg_read),
        .reg_write   (reg_write),
        .busy        (busy)
    );

    initial clk_usb = 1'b0;
    always #5 clk_usb = ~clk_usb;

    // Responder: registered read data 0xA0 + bytecnt, zero when not reading
    always @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)
            reg_datai <= 8'h00;
        else
            reg_datai <= reg_read ? (8'hA0 + 8'(reg_bytecnt)) : 8'h00;
    end

    // Bus / stream monitor: values seen at an edge belong to the cycle ending there
    always @(posedge clk_usb) begin
        cyc <= cyc + 1;
        if (reg_write) begin
            wr_t e;
            e.addr = reg_address;
            e.cnt  = reg_bytecnt;
            e.data = reg_datao;
            e.c    = cyc;
            wr_q.push_back(e);
        end
        if (reg_read)
            rd_cyc_q.push_back(cyc);
        if (reg_read && reg_write)
            both_cnt <= both_cnt + 1;
        if (m_valid && m_ready) begin
            m_q.push_back(m_data);
            m_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte, hold until accepted; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 2000) begin
            @(negedge clk_usb);
            n++;
        end
        if (n >= 2000)
            check("send_timeout", 32'(n), 32'd0);
        @(negedge clk_usb);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk_usb);
            n++;
        end
        if (n >= max_cyc)
            check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_cyc_q.delete();
        m_q.delete();
        m_cyc_q.delete();
    endtask

    initial begin
        int errs;
        int seen;
        int n;
        bit rdy_ok;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        both_cnt = 0;
        reset_n  = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        m_ready  = 1'b1;

        // Reset state
        #2;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {30'd0, reg_read, reg_write}, 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_addr", 32'(reg_address), 32'd0);
        check("rst_bytecnt", 32'(reg_bytecnt), 32'd0);
        check("rst_datao", 32'(reg_datao), 32'd0);
        repeat (2) @(negedge clk_usb);
        reset_n = 1'b1;
        @(negedge clk_usb);

        // Write: 00 05 04 11 22 33 44
        clear_logs();
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle(50);
        check("wr_count", 32'(wr_q.size()), 32'd4);
        if (wr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("wr_addr", 32'(wr_q[i].addr), 32'h05);
                check("wr_cnt", 32'(wr_q[i].cnt), 32'(i));
            end
            check("wr_data0", 32'(wr_q[0].data), 32'h11);
            check("wr_data3", 32'(wr_q[3].data), 32'h44);
            check("wr_back2back", 32'(wr_q[3].c - wr_q[0].c), 32'd3);
        end
        check("wr_idle_ready", 32'(s_ready), 32'd1);
        check("wr_hold_addr", 32'(reg_address), 32'h05);

        // Read with m_ready=1: 01 06 04
        clear_logs();
        m_ready = 1'b1;
        send_byte(8'h01); send_byte(8'h06); send_byte(8'h04);
        check("rd_s_ready_low", 32'(s_ready), 32'd0);
        wait_idle(100);
        check("rd_strobes", 32'(rd_cyc_q.size()), 32'd4);
        check("rd_bytes", 32'(m_q.size()), 32'd4);
        if (m_q.size() == 4 && rd_cyc_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("rd_data", 32'(m_q[i]), 32'(8'hA0 + i));
            check("rd_latency", 32'(m_cyc_q[0] - rd_cyc_q[0]), 32'd2);
            check("rd_back2back", 32'(rd_cyc_q[3] - rd_cyc_q[0]), 32'd3);
        end
        check("rd_no_overlap", 32'(both_cnt), 32'd0);

        // Backpressure: LEN=10 with m_ready low for 20 cycles
        clear_logs();
        m_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h06); send_byte(8'h0A);
        repeat (20) @(negedge clk_usb);
        check("bp_stall_strobes", 32'(rd_cyc_q.size()), 32'd4);
        check("bp_no_output", 32'(m_q.size()), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        wait_idle(200);
        check("bp_total_strobes", 32'(rd_cyc_q.size()), 32'd10);
        check("bp_bytes", 32'(m_q.size()), 32'd10);
        errs = 0;
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i] !== 8'hA0 + 8'(i)) errs++;
        check("bp_order", 32'(errs), 32'd0);

        // LEN=0 write: 256 bytes, bytecnt wraps at 128
        clear_logs();
        send_byte(8'h00); send_byte(8'h07); send_byte(8'h00);
        for (int i = 0; i < 256; i++)
            send_byte(8'(i));
        wait_idle(50);
        check("len0_count", 32'(wr_q.size()), 32'd256);
        if (wr_q.size() == 256) begin
            check("len0_cnt127", 32'(wr_q[127].cnt), 32'd127);
            check("len0_cnt128", 32'(wr_q[128].cnt), 32'd0);
            check("len0_cnt255", 32'(wr_q[255].cnt), 32'd127);
            check("len0_data200", 32'(wr_q[200].data), 32'd200);
            errs = 0;
            for (int i = 0; i < 256; i++)
                if (wr_q[i].cnt !== 7'(i % 128) || wr_q[i].data !== 8'(i)) errs++;
            check("len0_all", 32'(errs), 32'd0);
        end
        check("len0_idle", 32'(s_ready), 32'd1);

        // Gappy input: LEN=3, s_valid toggles every other cycle
        clear_logs();
        send_byte(8'h00); send_byte(8'h09); send_byte(8'h03);
        rdy_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!s_ready) rdy_ok = 1'b0;
            send_byte(8'hC0 + 8'(i));
            if (!s_ready && i < 2) rdy_ok = 1'b0;
            @(negedge clk_usb);
        end
        wait_idle(50);
        check("gap_ready", 32'(rdy_ok), 32'd1);
        check("gap_count", 32'(wr_q.size()), 32'd3);
        if (wr_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("gap_cnt", 32'(wr_q[i].cnt), 32'(i));
                check("gap_data", 32'(wr_q[i].data), 32'(8'hC0 + i));
            end
            check("gap_spacing", 32'(wr_q[1].c - wr_q[0].c), 32'd2);
        end

        // Reset mid-read after 2 of 4 strobes
        clear_logs();
        m_ready = 1'b1;
        send_byte(8'h01); send_byte(8'h06); send_byte(8'h04);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 100) begin
            if (reg_read) seen++;
            if (seen < 2) begin
                @(negedge clk_usb);
                n++;
            end
        end
        check("mid_reached", 32'(seen), 32'd2);
        check("mid_strobe_hi", 32'(reg_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rd_drop", 32'(reg_read), 32'd0);
        check("mid_m_valid", 32'(m_valid), 32'd0);
        check("mid_s_ready", 32'(s_ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        @(negedge clk_usb);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_usb);
        check("post_rst_quiet", {30'd0, m_valid, reg_read}, 32'd0);
        clear_logs();
        send_byte(8'h00); send_byte(8'h0A); send_byte(8'h02);
        send_byte(8'h5A); send_byte(8'hA5);
        wait_idle(50);
        check("post_wr_count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("post_wr_addr", 32'(wr_q[0].addr), 32'h0A);
            check("post_wr_d0", 32'(wr_q[0].data), 32'h5A);
            check("post_wr_d1", 32'(wr_q[1].data), 32'hA5);
            check("post_wr_cnt1", 32'(wr_q[1].cnt), 32'd1);
        end
        clear_logs();
        send_byte(8'h01); send_byte(8'h0B); send_byte(8'h02);
        wait_idle(50);
        check("post_rd_bytes", 32'(m_q.size()), 32'd2);
        if (m_q.size() == 2) begin
            check("post_rd_d0", 32'(m_q[0]), 32'hA0);
            check("post_rd_d1", 32'(m_q[1]), 32'hA1);
        end
        check("no_overlap_all", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
